// File: rtl/piezo_pkg.sv
// piezo_pkg: note table, one-hot codes and decoder states shared with the tone generator
package piezo_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  localparam logic [7:0] NOTE_NONE = 8'b0000_0000;
  localparam logic [7:0] NOTE_CODE [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  localparam logic [15:0] NOM_PERIOD [8] = '{16'd3832, 16'd3402, 16'd3032, 16'd2862,
                                             16'd2552, 16'd2272, 16'd2022, 16'd1912};
  // Windows are inclusive on both sides; legal tolerances keep them disjoint.
  function automatic logic [7:0] match_note(input logic [16:0] p, input logic [16:0] tol);
    logic [16:0] nom;
    match_note = NOTE_NONE;
    for (int k = 0; k < 8; k++) begin
      nom = {1'b0, NOM_PERIOD[k]};
      if (p + tol >= nom && p <= nom + tol) match_note = match_note | NOTE_CODE[k];
    end
  endfunction
endpackage

// File: rtl/tone_edge_sync.sv
// tone_edge_sync: two-flop synchroniser with a registered rising-edge pulse
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_pulse
);
  logic meta_q, sync_q, prev_q, pulse_q, pulse_d;
  always_comb pulse_d = sync_q & ~prev_q;
  always_ff @(posedge clk)
    if (rst) {meta_q, sync_q, prev_q, pulse_q} <= '0;
    else {meta_q, sync_q, prev_q, pulse_q} <= {tone_in, meta_q, sync_q, pulse_d};
  assign edge_pulse = pulse_q;
endmodule

// File: rtl/piezo_tone_decoder.sv
// piezo_tone_decoder: measures square-wave period and locks onto one of eight notes
module piezo_tone_decoder import piezo_pkg::*; #(
  parameter int TOL     = 32,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [7:0]  note,
  output logic        note_valid,
  output logic        note_change,
  output logic [15:0] period
);
  localparam logic [16:0] TO     = 17'(TIMEOUT);
  localparam logic [16:0] TOL_W  = 17'(TOL);
  localparam logic [2:0]  CONF_W = 3'(CONFIRM);
  logic        edge_pulse;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, period_q, period_d;
  logic [16:0] elapsed;
  logic [7:0]  match, last_q, last_d, note_q, note_d;
  logic [2:0]  conf_q, conf_d;
  logic        valid_q, valid_d, change_q, change_d;

  tone_edge_sync u_sync (.clk(clk), .rst(rst), .tone_in(tone_in), .edge_pulse(edge_pulse));

  // elapsed is the pulse-to-pulse distance if an edge pulse lands in this cycle
  always_comb begin
    elapsed  = {1'b0, cnt_q} + 17'd1;
    match    = match_note(elapsed, TOL_W);
    cnt_d    = edge_pulse ? '0 : ({1'b0, cnt_q} == TO ? cnt_q : cnt_q + 16'd1);
    state_d  = state_q;
    conf_d   = conf_q;
    last_d   = last_q;
    note_d   = note_q;
    valid_d  = valid_q;
    period_d = period_q;
    if (edge_pulse && state_q == IDLE) state_d = MEASURE;
    else if (edge_pulse) begin
      period_d = elapsed[15:0];
      last_d   = match;
      conf_d   = match == NOTE_NONE ? 3'd0 : match != last_q ? 3'd1 : conf_q == 3'd7 ? conf_q : conf_q + 3'd1;
      if (match == NOTE_NONE) begin
        note_d  = NOTE_NONE;
        valid_d = 1'b0;
        state_d = MEASURE;
      end else if (conf_d >= CONF_W) begin
        note_d  = match;
        valid_d = 1'b1;
        state_d = LOCKED;
      end
    end else if (state_q != IDLE && elapsed == TO) begin
      state_d = IDLE;
      note_d  = NOTE_NONE;
      valid_d = 1'b0;
      conf_d  = 3'd0;
      last_d  = NOTE_NONE;
    end
    change_d = note_d != note_q;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      conf_q   <= '0;
      last_q   <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      conf_q   <= conf_d;
      last_q   <= last_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      period_q <= period_d;
    end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign period      = period_q;
endmodule

// File: tb/tb_piezo_tone_decoder.sv
// tb_piezo_tone_decoder: directed scenarios for the piezo note decoder
module tb_piezo_tone_decoder;
  import piezo_pkg::*;
  localparam int TO = 3900;
  logic clk = 1'b0, rst = 1'b1, tone_in = 1'b0;
  logic [7:0] note;
  logic note_valid, note_change;
  logic [15:0] period;
  int n_cmp = 0, n_bad = 0, chg_cnt = 0, c0;

  piezo_tone_decoder #(.TOL(32), .CONFIRM(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in),
    .note(note), .note_valid(note_valid), .note_change(note_change), .period(period)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (note_change === 1'b1) chg_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wave(input int p);
    tone_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tone_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    do_reset();
    n_cmp++; if (note !== 8'h00) begin n_bad++; $display("FAIL reset_note got=%b exp=%b", note, 8'h00); end
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", note_valid); end
    n_cmp++; if (note_change !== 1'b0) begin n_bad++; $display("FAIL reset_change got=%b exp=0", note_change); end
    n_cmp++; if (period !== 16'd0) begin n_bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_c4_lock;
    c0 = chg_cnt;
    wave(3832);
    wave(3832);
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL c4_prelock_valid got=%b exp=0", note_valid); end
    n_cmp++; if (period !== 16'd3832) begin n_bad++; $display("FAIL c4_period got=%0d exp=3832", period); end
    tone_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (note !== 8'h00) begin n_bad++; $display("FAIL c4_early_note got=%b exp=%b", note, 8'h00); end
    @(negedge clk);
    n_cmp++; if (note !== 8'h01) begin n_bad++; $display("FAIL c4_note got=%b exp=%b", note, 8'h01); end
    n_cmp++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL c4_valid got=%b exp=1", note_valid); end
    n_cmp++; if (note_change !== 1'b1) begin n_bad++; $display("FAIL c4_change got=%b exp=1", note_change); end
    @(negedge clk);
    n_cmp++; if (note_change !== 1'b0) begin n_bad++; $display("FAIL c4_change_width got=%b exp=0", note_change); end
    repeat (1911) @(negedge clk);
    tone_in = 1'b0;
    repeat (1916) @(negedge clk);
    n_cmp++; if (chg_cnt !== c0 + 1) begin n_bad++; $display("FAIL c4_change_count got=%0d exp=%0d", chg_cnt - c0, 1); end
  endtask

  task automatic test_switch;
    c0 = chg_cnt;
    wave(1912);
    wave(1912);
    n_cmp++; if (note !== 8'h01) begin n_bad++; $display("FAIL switch_hold got=%b exp=%b", note, 8'h01); end
    n_cmp++; if (period !== 16'd1912) begin n_bad++; $display("FAIL switch_period got=%0d exp=1912", period); end
    wave(1912);
    n_cmp++; if (note !== 8'h80) begin n_bad++; $display("FAIL switch_note got=%b exp=%b", note, 8'h80); end
    n_cmp++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL switch_valid got=%b exp=1", note_valid); end
    n_cmp++; if (chg_cnt !== c0 + 1) begin n_bad++; $display("FAIL switch_change_count got=%0d exp=1", chg_cnt - c0); end
  endtask

  task automatic test_reset_locked;
    tone_in = 1'b1;
    repeat (100) @(negedge clk);
    do_reset();
    n_cmp++; if (note !== 8'h00) begin n_bad++; $display("FAIL rstlock_note got=%b exp=%b", note, 8'h00); end
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL rstlock_valid got=%b exp=0", note_valid); end
    n_cmp++; if (period !== 16'd0) begin n_bad++; $display("FAIL rstlock_period got=%0d exp=0", period); end
    n_cmp++; if (note_change !== 1'b0) begin n_bad++; $display("FAIL rstlock_change got=%b exp=0", note_change); end
    wave(3832);
    wave(3832);
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL rstlock_early got=%b exp=0", note_valid); end
    wave(3832);
    n_cmp++; if (note !== 8'h01) begin n_bad++; $display("FAIL rstlock_relock got=%b exp=%b", note, 8'h01); end
  endtask

  task automatic test_timeout;
    repeat (TO + 3 - 3832) @(negedge clk);
    n_cmp++; if (note !== 8'h01) begin n_bad++; $display("FAIL timeout_early got=%b exp=%b", note, 8'h01); end
    @(negedge clk);
    n_cmp++; if (note !== 8'h00) begin n_bad++; $display("FAIL timeout_note got=%b exp=%b", note, 8'h00); end
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_valid got=%b exp=0", note_valid); end
    n_cmp++; if (note_change !== 1'b1) begin n_bad++; $display("FAIL timeout_change got=%b exp=1", note_change); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL timeout_state got=%0d exp=%0d", dut.state_q, IDLE); end
    wave(500);
    n_cmp++; if (period !== 16'd3832) begin n_bad++; $display("FAIL timeout_first_edge got=%0d exp=3832", period); end
    n_cmp++; if (dut.state_q !== MEASURE) begin n_bad++; $display("FAIL timeout_restart got=%0d exp=%0d", dut.state_q, MEASURE); end
  endtask

  task automatic test_unmatch;
    do_reset();
    c0 = chg_cnt;
    wave(3064);
    wave(3000);
    wave(3065);
    n_cmp++; if (note !== 8'h04) begin n_bad++; $display("FAIL e4_note got=%b exp=%b", note, 8'h04); end
    n_cmp++; if (period !== 16'd3000) begin n_bad++; $display("FAIL e4_period got=%0d exp=3000", period); end
    wave(3000);
    n_cmp++; if (note !== 8'h00) begin n_bad++; $display("FAIL unmatch_note got=%b exp=%b", note, 8'h00); end
    n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL unmatch_valid got=%b exp=0", note_valid); end
    n_cmp++; if (period !== 16'd3065) begin n_bad++; $display("FAIL unmatch_period got=%0d exp=3065", period); end
    n_cmp++; if (chg_cnt !== c0 + 2) begin n_bad++; $display("FAIL unmatch_change_count got=%0d exp=2", chg_cnt - c0); end
  endtask

  task automatic test_no_match;
    do_reset();
    c0 = chg_cnt;
    for (int i = 0; i < 6; i++) begin
      wave(2700);
      n_cmp++; if (note !== 8'h00 || note_valid !== 1'b0) begin n_bad++; $display("FAIL nomatch_%0d note=%b valid=%b exp=0", i, note, note_valid); end
    end
    n_cmp++; if (period !== 16'd2700) begin n_bad++; $display("FAIL nomatch_period got=%0d exp=2700", period); end
    n_cmp++; if (chg_cnt !== c0) begin n_bad++; $display("FAIL nomatch_changes got=%0d exp=0", chg_cnt - c0); end
  endtask

  task automatic test_priority;
    do_reset();
    wave(TO);
    tone_in = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (period !== 16'(TO)) begin n_bad++; $display("FAIL prio_period got=%0d exp=%0d", period, TO); end
    n_cmp++; if (dut.state_q !== MEASURE) begin n_bad++; $display("FAIL prio_state got=%0d exp=%0d", dut.state_q, MEASURE); end
    tone_in = 1'b0;
    repeat (TO) @(negedge clk);
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL prio_timeout got=%0d exp=%0d", dut.state_q, IDLE); end
    wave(100);
    n_cmp++; if (period !== 16'(TO)) begin n_bad++; $display("FAIL prio_idle_edge got=%0d exp=%0d", period, TO); end
  endtask

  initial begin
    test_reset();
    test_c4_lock();
    test_switch();
    test_reset_locked();
    test_timeout();
    test_unmatch();
    test_no_match();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/piezo_tone_decoder.md
PIEZO_TONE_DECODER -- requirements
Module: piezo_tone_decoder

Interface
REQ-001 SHALL have parameter TOL, default 32: period match tolerance in clk cycles; legal range 0..54.
REQ-002 SHALL have parameter CONFIRM, default 2: consecutive matching periods required to lock a note; legal range 1..7.
REQ-003 SHALL have parameter TIMEOUT, default 8191: clk cycles without a rising edge before declaring silence; legal range 3833..65535.
REQ-004 SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port tone_in, input, 1: asynchronous square wave from the piezo or comparator line.
REQ-007 SHALL have port note, output, 8: one-hot note, bit0=C4 through bit7=C5; 0 means none.
REQ-008 SHALL have port note_valid, output, 1: high while note is locked.
REQ-009 SHALL have port note_change, output, 1: one-cycle pulse whenever note changes value.
REQ-010 SHALL have port period, output, 16: last measured period in clk cycles.

Function
REQ-011 SHALL synchronise tone_in through two flops and detect rising edges on the synchronised signal, giving a 3-cycle input-to-edge-pulse latency.
REQ-012 SHALL define period as the clk-cycle distance between consecutive edge pulses (pulses at cycles 10 and 3842 give 3832).
REQ-013 SHALL use a 16-bit cycle counter that clears on each edge pulse and saturates at TIMEOUT.
REQ-014 SHALL use the nominal periods C4 3832, D4 3402, E4 3032, F4 2862, G4 2552, A4 2272, B4 2022, C5 1912.
REQ-015 SHALL count a period as matching note k when |period - NOM_k| <= TOL, with both bounds inclusive; the windows never overlap.
REQ-016 SHALL use states IDLE, MEASURE and LOCKED.
REQ-017 IDLE: the first edge pulse SHALL start the counter and move to MEASURE, and SHALL NOT produce a period.
REQ-018 MEASURE/LOCKED: each later edge pulse SHALL update the period output on the following cycle and classify the measured value.
REQ-019 SHALL increment a confirm counter when a period matches the same note as the previous period, and reset it to 1 on a different match.
REQ-020 SHALL lock when the confirm count reaches CONFIRM: note set to the match, note_valid=1, state LOCKED, in the cycle after the deciding edge.
REQ-021 An unmatched period SHALL clear the confirm count, set note=0 and note_valid=0, and return to MEASURE.
REQ-022 When the counter reaches TIMEOUT without an edge, SHALL set note=0 and note_valid=0 and go to IDLE.
REQ-023 SHALL pulse note_change for exactly one cycle, concurrent with the note register update, only if the new note differs from the old; relock to the same note gives no pulse.
REQ-024 An edge pulse in the same cycle the counter reaches TIMEOUT SHALL take priority: the period is measured and the timeout is ignored.
REQ-025 A note switch while LOCKED SHALL hold the old note until the new note confirms; no intermediate 0 unless a period is unmatched.

Reset
REQ-026 rst SHALL clear note, note_valid, note_change, period, the counter, the confirm count and the synchroniser flops, and set state IDLE.
REQ-027 rst asserted mid-measurement or while LOCKED SHALL discard any partial period; the first edge after reset SHALL be treated as an IDLE first edge.

Structure
REQ-028 A shared package piezo_pkg SHALL hold the nominal period table, the one-hot note codes and the state enum, shared with the tone generator.
REQ-029 The synchroniser and edge detector SHALL be a sub-module named tone_edge_sync.
REQ-030 Classification SHALL be a registered compare over the eight windows; no divider is permitted.

Verification
REQ-031 Square wave with period 3832 from reset -> after 3 edges note=8'b00000001, note_valid=1, one note_change pulse.
REQ-032 Locked C4, switch to period 1912 -> C4 held for 1 period, then note=8'b10000000 with one note_change pulse.
REQ-033 Periods 3064 and 3000 -> E4 locks; period 3065 -> note=0, note_valid=0, note_change pulse.
REQ-034 Period 2700 for 5 periods -> note stays 0, note_valid stays 0, no pulses.
REQ-035 Locked note, tone_in held low -> note=0 exactly TIMEOUT cycles after the last edge, state IDLE.
REQ-036 rst for 1 cycle while LOCKED -> all outputs 0 next cycle; relock needs CONFIRM+1 further edges.
